rs_alloc_tracker: RTL and testbench
===================================

Name: rs_alloc_tracker

Overview:
- Per-reservation-station entry allocator in the dispatch stage.
- Consumes the per-type request pair and request count produced by the dispatch RS request generator, one instance per RS type (ALU, branch, mul, ldst).
- Tracks busy entries, picks free entry indices for up to two dispatching instructions per cycle, and reports whether the request can be satisfied.
- Releases entries on issue and clears all entries on pipeline kill.

Parameters:
- ENT_NUM, 8, number of RS entries tracked (power of two, at least 2).
- ENT_SEL, 3, entry index width, equal to log2(ENT_NUM).

Ports:
- clk_i  in  1  core clock, all state on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- req1_i  in  1  instruction 1 requests an entry of this RS type
- req2_i  in  1  instruction 2 requests an entry of this RS type
- req_num_i  in  2  request count (0..2), always equal to req1_i + req2_i
- stall_dp_i  in  1  dispatch stalled by another source; no allocation this cycle
- kill_i  in  1  pipeline flush; frees all entries
- issue_valid_i  in  1  an entry is issued and released this cycle
- issue_ent_i  in  ENT_SEL  index of the released entry
- alloc_ok_o  out  1  free entries >= req_num_i (combinational from registered state)
- alloc_en1_o  out  1  entry granted to instruction 1 this cycle
- alloc_en2_o  out  1  entry granted to instruction 2 this cycle
- alloc_ent1_o  out  ENT_SEL  entry index for instruction 1
- alloc_ent2_o  out  ENT_SEL  entry index for instruction 2
- busy_vec_o  out  ENT_NUM  registered busy bit per entry
- free_cnt_o  out  ENT_SEL+1  registered count of free entries

Behaviour:
- Reset (async, rst_n_i low): busy_vec_o = 0, free_cnt_o = ENT_NUM. Outputs then follow from state: alloc_ok_o = 1, alloc_en1_o = alloc_en2_o = 0, alloc_ent1_o = alloc_ent2_o = 0.
- Reset deasserted mid-operation: all prior allocations are lost; state is as after reset.
- Fire condition: fire = (req_num_i != 0) & alloc_ok_o & ~stall_dp_i & ~kill_i.
  - alloc_en1_o = fire & req1_i.
  - alloc_en2_o = fire & req2_i.
- Entry selection is combinational on the current registered busy_vec_o:
  - low0 = lowest-index free entry; low1 = second-lowest free entry.
  - Both requests: ent1 = low0, ent2 = low1.
  - Only req2_i: ent2 = low0.
  - Only req1_i: ent1 = low0.
  - Index outputs are 0 when the corresponding enable is low.
- Allocation latency: busy bits for granted entries set at the next edge. Entries never granted twice.
- Release: issue_valid_i clears busy[issue_ent_i] at the next edge.
  - No bypass: a freed entry is not allocatable until the following cycle.
  - Releasing an already-free entry is ignored; free_cnt_o is unchanged.
- Simultaneous allocation and release in one cycle: both are applied.
  - free_cnt_next = free_cnt + rel - (alloc_en1 + alloc_en2), where rel = 1 only if the released entry was busy.
  - The grant never targets the released entry, because that entry is still busy this cycle.
- Kill: highest priority over allocation and release. At the next edge busy_vec_o = 0 and free_cnt_o = ENT_NUM. Grants are suppressed in the kill cycle.
- Full (free_cnt_o = 0): alloc_ok_o = 0 for req_num_i >= 1. Releases still accepted.
- Free = 1 with req_num_i = 2: alloc_ok_o = 0; both requests stalled (all-or-nothing, no partial grant).
- Empty (free_cnt_o = ENT_NUM): allocation is always satisfiable.
- Invariant: free_cnt_o == ENT_NUM - popcount(busy_vec_o) at every edge.

Optional Feature:
- Macro: RS_ALLOC_PERF_EN.
- Defined: adds output alloc_stall_cnt_o [31:0].
  - Increments each cycle where req_num_i != 0 & ~alloc_ok_o & ~kill_i.
  - Saturates at 0xFFFFFFFF.
  - Cleared only by rst_n_i, not by kill_i.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan (ENT_NUM = 8):
- After reset, req1 = req2 = 1, req_num = 2 → alloc_ok = 1, ent1 = 0, ent2 = 1; next cycle busy_vec = 0x03, free_cnt = 6.
- busy_vec = 0x05, req2 only, req_num = 1 → alloc_en2 = 1, ent2 = 1, alloc_en1 = 0; next busy_vec = 0x07.
- busy_vec = 0x7F, req_num = 2 → alloc_ok = 0, no grants. Same cycle issue_ent = 3 → next busy_vec = 0x77, free_cnt = 2, and a later req_num = 2 grants entries 3 and 7.
- busy_vec = 0xFF, release entry 4 and req_num = 1 in the same cycle → no grant that cycle; next busy_vec = 0xEF, free_cnt = 1; following cycle grants entry 4.
- busy_vec = 0xAA, kill with req_num = 2 and issue_ent = 1 → no grants; next busy_vec = 0x00, free_cnt = 8.
- Release entry 2 with busy_vec = 0x01 → ignored, busy_vec = 0x01, free_cnt = 7. With RS_ALLOC_PERF_EN, 5 full-stall cycles → alloc_stall_cnt_o = 5.

Source files
------------

// File: rtl/rs_alloc_tracker.sv
// ---------------------------------------------------------------------------
// rs_alloc_tracker
//
// Entry allocator for one reservation station in the dispatch stage. Each
// instance serves one RS type (ALU, branch, mul, ldst). The allocator keeps a
// busy bit per RS entry and picks free entry indices for up to two
// dispatching instructions per cycle. Entries are released on issue, and all
// entries are cleared on a pipeline kill.
//
// Handshake: the request pair (req1_i/req2_i, req_num_i) is a request that
// may be held. alloc_ok_o is the acceptance indication. The request is taken
// only in a cycle where fire = (req_num_i != 0) & alloc_ok_o & ~stall_dp_i &
// ~kill_i. Grants are all-or-nothing. The granted entries become busy at the
// next rising edge.
//
// Ports:
//   clk_i, rst_n_i        clock and asynchronous active-low reset
//   req1_i, req2_i        per-instruction entry requests
//   req_num_i             request count (req1_i + req2_i)
//   stall_dp_i            dispatch stalled elsewhere; no allocation
//   kill_i                pipeline flush; frees every entry
//   issue_valid_i/ent_i   release of one entry on issue
//   alloc_ok_o            enough free entries for req_num_i
//   alloc_en1/2_o         grant strobes for instruction 1/2
//   alloc_ent1/2_o        granted entry indices (0 when not granted)
//   busy_vec_o            registered busy bit per entry
//   free_cnt_o            registered free-entry count
//
// Optional: define RS_ALLOC_PERF_EN to add alloc_stall_cnt_o. This is a
// saturating count of cycles in which a request was refused for lack of
// entries. Only rst_n_i clears the count.
// ---------------------------------------------------------------------------
module rs_alloc_tracker #(
    parameter int ENT_NUM = 8,
    parameter int ENT_SEL = 3
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               req1_i,
    input  logic               req2_i,
    input  logic [1:0]         req_num_i,
    input  logic               stall_dp_i,
    input  logic               kill_i,
    input  logic               issue_valid_i,
    input  logic [ENT_SEL-1:0] issue_ent_i,
    output logic               alloc_ok_o,
    output logic               alloc_en1_o,
    output logic               alloc_en2_o,
    output logic [ENT_SEL-1:0] alloc_ent1_o,
    output logic [ENT_SEL-1:0] alloc_ent2_o,
    output logic [ENT_NUM-1:0] busy_vec_o,
    output logic [ENT_SEL:0]   free_cnt_o
`ifdef RS_ALLOC_PERF_EN
    ,
    output logic [31:0]        alloc_stall_cnt_o
`endif
);

    logic [ENT_NUM-1:0] busy_q, busy_nxt;
    logic [ENT_SEL:0]   free_q, free_nxt;
    logic [ENT_SEL-1:0] low0, low1;
    logic               found0, found1;
    logic               fire, rel;

    // Find the two lowest free entries. Only the registered busy vector is
    // used, so an entry released this cycle is not yet a candidate.
    always_comb begin
        low0   = '0;
        low1   = '0;
        found0 = 1'b0;
        found1 = 1'b0;
        for (int i = 0; i < ENT_NUM; i++) begin
            if (!busy_q[i]) begin
                if (!found0) begin
                    low0   = ENT_SEL'(i);
                    found0 = 1'b1;
                end else if (!found1) begin
                    low1   = ENT_SEL'(i);
                    found1 = 1'b1;
                end
            end
        end
    end

    assign alloc_ok_o  = (free_q >= (ENT_SEL+1)'(req_num_i));
    assign fire        = (req_num_i != 2'd0) & alloc_ok_o & ~stall_dp_i & ~kill_i;
    assign alloc_en1_o = fire & req1_i;
    assign alloc_en2_o = fire & req2_i;

    // Instruction 2 takes the second free slot only when instruction 1 also
    // requests an entry. Otherwise it takes the lowest free slot.
    assign alloc_ent1_o = alloc_en1_o ? low0 : '0;
    assign alloc_ent2_o = alloc_en2_o ? (req1_i ? low1 : low0) : '0;

    // A release counts only when it frees a busy entry, so a stray release
    // of an already-free entry leaves the count unchanged.
    assign rel = issue_valid_i & busy_q[issue_ent_i];

    always_comb begin
        busy_nxt = busy_q;
        free_nxt = free_q + (ENT_SEL+1)'(rel)
                          - (ENT_SEL+1)'(alloc_en1_o)
                          - (ENT_SEL+1)'(alloc_en2_o);
        if (rel)
            busy_nxt[issue_ent_i] = 1'b0;
        if (alloc_en1_o)
            busy_nxt[alloc_ent1_o] = 1'b1;
        if (alloc_en2_o)
            busy_nxt[alloc_ent2_o] = 1'b1;
        if (kill_i) begin
            busy_nxt = '0;
            free_nxt = (ENT_SEL+1)'(ENT_NUM);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q <= '0;
            free_q <= (ENT_SEL+1)'(ENT_NUM);
        end else begin
            busy_q <= busy_nxt;
            free_q <= free_nxt;
        end
    end

    assign busy_vec_o = busy_q;
    assign free_cnt_o = free_q;

`ifdef RS_ALLOC_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            stall_cnt_q <= '0;
        else if ((req_num_i != 2'd0) && !alloc_ok_o && !kill_i && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign alloc_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rs_alloc_tracker.sv
module tb_rs_alloc_tracker;

    localparam int ENT_NUM = 8;
    localparam int ENT_SEL = 3;

    logic               clk;
    logic               rst_n;
    logic               req1, req2;
    logic [1:0]         req_num;
    logic               stall_dp, kill, issue_valid;
    logic [ENT_SEL-1:0] issue_ent;
    logic               alloc_ok, alloc_en1, alloc_en2;
    logic [ENT_SEL-1:0] alloc_ent1, alloc_ent2;
    logic [ENT_NUM-1:0] busy_vec;
    logic [ENT_SEL:0]   free_cnt;
`ifdef RS_ALLOC_PERF_EN
    logic [31:0]        stall_cnt;
`endif

    rs_alloc_tracker #(.ENT_NUM(ENT_NUM), .ENT_SEL(ENT_SEL)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .req1_i        (req1),
        .req2_i        (req2),
        .req_num_i     (req_num),
        .stall_dp_i    (stall_dp),
        .kill_i        (kill),
        .issue_valid_i (issue_valid),
        .issue_ent_i   (issue_ent),
        .alloc_ok_o    (alloc_ok),
        .alloc_en1_o   (alloc_en1),
        .alloc_en2_o   (alloc_en2),
        .alloc_ent1_o  (alloc_ent1),
        .alloc_ent2_o  (alloc_ent2),
        .busy_vec_o    (busy_vec),
        .free_cnt_o    (free_cnt)
`ifdef RS_ALLOC_PERF_EN
        ,
        .alloc_stall_cnt_o (stall_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int  n_chk  = 0;
    int  n_fail = 0;
    bit  busy_m[ENT_NUM];      // reference: which entries hold an instruction
    longint stall_m;           // reference stall count

    // Values sampled from the DUT in the most recent step.
    logic       obs_ok, obs_en1, obs_en2;
    logic [2:0] obs_e1, obs_e2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] busy_pack();
        logic [7:0] v;
        for (int i = 0; i < ENT_NUM; i++) v[i] = busy_m[i];
        return v;
    endfunction

    function automatic int free_m();
        int c;
        c = 0;
        for (int i = 0; i < ENT_NUM; i++) if (!busy_m[i]) c++;
        return c;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENT_NUM; i++) busy_m[i] = 1'b0;
        stall_m = 0;
    endfunction

    // Check registered state against the model.
    task automatic chk_state(input string tag);
        chk({tag, "_busy"}, 32'(busy_vec), 32'(busy_pack()));
        chk({tag, "_free"}, 32'(free_cnt), 32'(free_m()));
`ifdef RS_ALLOC_PERF_EN
        chk({tag, "_stall"}, stall_cnt, 32'(stall_m));
`endif
    endtask

    // One cycle: drive at the falling edge, check the combinational grant
    // outputs mid low phase, advance the model across the rising edge, and
    // check the state at the next falling edge.
    task automatic step(input bit r1, input bit r2, input bit st, input bit kl,
                        input bit iv, input int ie);
        int  fl[$];
        int  rn;
        bit  ok, fire, e1, e2;
        int  x1, x2;
        req1        = r1;
        req2        = r2;
        req_num     = 2'(int'(r1) + int'(r2));
        stall_dp    = st;
        kill        = kl;
        issue_valid = iv;
        issue_ent   = 3'(ie);

        // Free entries in ascending order; grants come from the front.
        fl = {};
        for (int i = 0; i < ENT_NUM; i++) if (!busy_m[i]) fl.push_back(i);
        rn   = int'(r1) + int'(r2);
        ok   = fl.size() >= rn;
        fire = (rn != 0) && ok && !st && !kl;
        e1   = fire && r1;
        e2   = fire && r2;
        x1   = e1 ? fl[0] : 0;
        x2   = 0;
        if (e2) x2 = r1 ? fl[1] : fl[0];

        #2;
        obs_ok  = alloc_ok;
        obs_en1 = alloc_en1;
        obs_en2 = alloc_en2;
        obs_e1  = alloc_ent1;
        obs_e2  = alloc_ent2;
        chk("ok",   32'(alloc_ok),   32'(ok));
        chk("en1",  32'(alloc_en1),  32'(e1));
        chk("en2",  32'(alloc_en2),  32'(e2));
        chk("ent1", 32'(alloc_ent1), 32'(x1));
        chk("ent2", 32'(alloc_ent2), 32'(x2));

        @(posedge clk);
        if ((rn != 0) && !ok && !kl && stall_m != 64'hFFFF_FFFF) stall_m++;
        if (kl) begin
            for (int i = 0; i < ENT_NUM; i++) busy_m[i] = 1'b0;
        end else begin
            if (iv) busy_m[ie] = 1'b0;
            if (e1) busy_m[x1] = 1'b1;
            if (e2) busy_m[x2] = 1'b1;
        end
        @(negedge clk);
        chk_state("st");
    endtask

    // Build an arbitrary busy pattern: kill, fill all, then release the
    // entries that should be free.
    task automatic set_busy(input logic [7:0] p);
        step(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < ENT_NUM / 2; k++) step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < ENT_NUM; i++) if (!p[i]) step(0, 0, 0, 0, 1, i);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n = 1'b0;
        req1 = 0; req2 = 0; req_num = 0; stall_dp = 0; kill = 0;
        issue_valid = 0; issue_ent = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy_vec), 32'h0);
        chk("rst_free", 32'(free_cnt), 32'd8);
        chk("rst_ok",   32'(alloc_ok), 32'd1);
        chk("rst_en1",  32'(alloc_en1), 32'd0);
        chk("rst_en2",  32'(alloc_en2), 32'd0);
        chk("rst_ent1", 32'(alloc_ent1), 32'd0);
        chk("rst_ent2", 32'(alloc_ent2), 32'd0);
        rst_n = 1'b1;

        // Double request from empty.
        step(1, 1, 0, 0, 0, 0);
        chk("tp1_ok",   32'(obs_ok), 32'd1);
        chk("tp1_ent1", 32'(obs_e1), 32'd0);
        chk("tp1_ent2", 32'(obs_e2), 32'd1);
        chk("tp1_busy", 32'(busy_vec), 32'h03);
        chk("tp1_free", 32'(free_cnt), 32'd6);

        // Only instruction 2 requests.
        set_busy(8'h05);
        step(0, 1, 0, 0, 0, 0);
        chk("tp2_en1",  32'(obs_en1), 32'd0);
        chk("tp2_en2",  32'(obs_en2), 32'd1);
        chk("tp2_ent2", 32'(obs_e2), 32'd1);
        chk("tp2_busy", 32'(busy_vec), 32'h07);

        // One free, two requested: stall; release same cycle with no bypass.
        set_busy(8'h7F);
        step(1, 1, 0, 0, 1, 3);
        chk("tp3_ok",   32'(obs_ok), 32'd0);
        chk("tp3_en1",  32'(obs_en1), 32'd0);
        chk("tp3_busy", 32'(busy_vec), 32'h77);
        chk("tp3_free", 32'(free_cnt), 32'd2);
        step(1, 1, 0, 0, 0, 0);
        chk("tp3_ent1", 32'(obs_e1), 32'd3);
        chk("tp3_ent2", 32'(obs_e2), 32'd7);

        // Full: release and request together.
        set_busy(8'hFF);
        step(1, 0, 0, 0, 1, 4);
        chk("tp4_en1",  32'(obs_en1), 32'd0);
        chk("tp4_busy", 32'(busy_vec), 32'hEF);
        chk("tp4_free", 32'(free_cnt), 32'd1);
        step(1, 0, 0, 0, 0, 0);
        chk("tp4_en1b", 32'(obs_en1), 32'd1);
        chk("tp4_ent1", 32'(obs_e1), 32'd4);

        // Kill beats allocation and release.
        set_busy(8'hAA);
        step(1, 1, 0, 1, 1, 1);
        chk("tp5_en1",  32'(obs_en1), 32'd0);
        chk("tp5_en2",  32'(obs_en2), 32'd0);
        chk("tp5_busy", 32'(busy_vec), 32'h00);
        chk("tp5_free", 32'(free_cnt), 32'd8);

        // Release of an already-free entry.
        set_busy(8'h01);
        step(0, 0, 0, 0, 1, 2);
        chk("tp6_busy", 32'(busy_vec), 32'h01);
        chk("tp6_free", 32'(free_cnt), 32'd7);

        // Stall dispatch: no grants even with space.
        step(1, 1, 1, 0, 0, 0);
        chk("stall_en1", 32'(obs_en1), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, ENT_NUM - 1)));
        end

        // Mid-operation reset loses all allocations.
        set_busy(8'h5A);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mrst_busy", 32'(busy_vec), 32'h0);
        chk("mrst_free", 32'(free_cnt), 32'd8);
        chk("mrst_ok",   32'(alloc_ok), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        chk_state("mrst");

        // Full-stall cycles counted by the performance counter.
        for (int k = 0; k < ENT_NUM / 2; k++) step(1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0, 0);
`ifdef RS_ALLOC_PERF_EN
        chk("perf_cnt", stall_cnt, 32'd5);
`endif
        chk("full_free", 32'(free_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
